// File: rtl/char_rom_arbiter.sv
// char_rom_arbiter
//
// Shares one character-glyph ROM (13-bit address = {char code, glyph pixel
// address}, 1-bit data) between N text-overlay requesters. At most one
// request is granted per cycle. The granted address is registered onto
// rom_address, and each returned pixel bit is tagged with the ID of the
// requester it belongs to. Responses come back in grant order.
//
// Configuration macro:
//   CHAR_ARB_FIXED_PRIO_EN - when defined, the round-robin pointer is removed
//                            and the lowest-index active request always wins.
//                            When undefined, arbitration is round-robin.
//
// Parameters:
//   N        number of requesters (2..8)
//   ID_W     requester-ID width, 2**ID_W >= N
//   ROM_LAT  cycles from rom_address register output to valid rom_q (1..3)
//
// Ports:
//   NCLK         system clock, rising edge
//   RST          synchronous active-high reset
//   req          per-requester read request, held until granted
//   req_char     7-bit character code per requester, slice i = [7i+6:7i]
//   req_addr     6-bit glyph address per requester,  slice i = [6i+5:6i]
//   gnt          one-hot grant, combinational, same cycle as accepted req
//   rom_address  registered ROM address of the last granted request
//   rom_q        ROM data output
//   rsp_valid    single-cycle pulse per grant, registered
//   rsp_id       requester the response belongs to, registered
//   rsp_data     returned pixel bit, registered
module char_rom_arbiter #(
    parameter int N       = 4,
    parameter int ID_W    = 2,
    parameter int ROM_LAT = 1
) (
    input  logic            NCLK,
    input  logic            RST,
    input  logic [N-1:0]    req,
    input  logic [7*N-1:0]  req_char,
    input  logic [6*N-1:0]  req_addr,
    output logic [N-1:0]    gnt,
    output logic [12:0]     rom_address,
    input  logic            rom_q,
    output logic            rsp_valid,
    output logic [ID_W-1:0] rsp_id,
    output logic            rsp_data
);

    logic            found;
    logic [ID_W-1:0] g_idx;
    logic [12:0]     sel_addr;

    // In-flight tracking: token k is visible ROM address + k cycles after grant
    logic [ROM_LAT:0] vld_p;
    logic [ID_W-1:0]  id_p [ROM_LAT+1];

`ifndef CHAR_ARB_FIXED_PRIO_EN
    // Index where the next search starts; reset to 0 so requester 0 leads
    logic [ID_W-1:0] ptr;
`endif

    always_comb begin
        found = 1'b0;
        g_idx = '0;
`ifdef CHAR_ARB_FIXED_PRIO_EN
        // Descending scan so the lowest active index is the last one written
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                g_idx = ID_W'(i);
            end
        end
`else
        // Rotating search: step k looks at (ptr + k) mod N; first hit wins
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[i] && (i == (int'(ptr) + k) % N)) begin
                    found = 1'b1;
                    g_idx = ID_W'(i);
                end
            end
        end
`endif
        if (RST) begin
            found = 1'b0;
        end

        gnt      = '0;
        sel_addr = '0;
        for (int i = 0; i < N; i++) begin
            if (found && (g_idx == ID_W'(i))) begin
                gnt[i]   = 1'b1;
                sel_addr = {req_char[7*i +: 7], req_addr[6*i +: 6]};
            end
        end
    end

    // Stage p0: grant registered into rom_address and the token pipeline
    always_ff @(posedge NCLK) begin
        if (RST) begin
            rom_address <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_data    <= 1'b0;
            vld_p       <= '0;
`ifndef CHAR_ARB_FIXED_PRIO_EN
            ptr         <= '0;
`endif
        end else begin
            if (found) begin
                rom_address <= sel_addr;
`ifndef CHAR_ARB_FIXED_PRIO_EN
                ptr         <= (int'(g_idx) == N - 1) ? '0 : g_idx + 1'b1;
`endif
            end
            vld_p <= {vld_p[ROM_LAT-1:0], found};
            // Last stage: token lines up with the ROM data for its address
            rsp_valid <= vld_p[ROM_LAT];
            if (vld_p[ROM_LAT]) begin
                rsp_id   <= id_p[ROM_LAT];
                rsp_data <= rom_q;
            end
        end
    end

    // IDs only matter alongside a set valid bit, so they carry no reset
    always_ff @(posedge NCLK) begin
        id_p[0] <= g_idx;
        for (int i = 1; i <= ROM_LAT; i++) begin
            id_p[i] <= id_p[i-1];
        end
    end

endmodule

// File: tb/tb_char_rom_arbiter.sv
module tb_char_rom_arbiter;
    localparam int N     = 4;
    localparam int ID_W  = 2;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic            NCLK = 1'b0;
    logic            RST  = 1'b1;
    logic [N-1:0]    req  = '0;
    logic [7*N-1:0]  req_char = '0;
    logic [6*N-1:0]  req_addr = '0;

    logic [N-1:0]    gnt_a, gnt_b;
    logic [12:0]     rom_address_a, rom_address_b;
    logic            rom_q_a, rom_q_b;
    logic            rsp_valid_a, rsp_valid_b;
    logic [ID_W-1:0] rsp_id_a, rsp_id_b;
    logic            rsp_data_a, rsp_data_b;

    always #5 NCLK = ~NCLK;

    char_rom_arbiter #(.N(N), .ID_W(ID_W), .ROM_LAT(LAT_A)) u_dut_a (
        .NCLK(NCLK), .RST(RST), .req(req), .req_char(req_char), .req_addr(req_addr),
        .gnt(gnt_a), .rom_address(rom_address_a), .rom_q(rom_q_a),
        .rsp_valid(rsp_valid_a), .rsp_id(rsp_id_a), .rsp_data(rsp_data_a)
    );

    char_rom_arbiter #(.N(N), .ID_W(ID_W), .ROM_LAT(LAT_B)) u_dut_b (
        .NCLK(NCLK), .RST(RST), .req(req), .req_char(req_char), .req_addr(req_addr),
        .gnt(gnt_b), .rom_address(rom_address_b), .rom_q(rom_q_b),
        .rsp_valid(rsp_valid_b), .rsp_id(rsp_id_b), .rsp_data(rsp_data_b)
    );

    // Glyph ROM contents: an arbitrary but fixed bit per address
    function automatic logic rom_fn(input logic [12:0] a);
        return (^(a & 13'h15B3)) ^ (a[12] & a[1]);
    endfunction

    // ROM models: data appears LAT cycles after the address is presented
    logic [12:0] dly_a [LAT_A];
    logic [12:0] dly_b [LAT_B];
    always @(posedge NCLK) begin
        dly_a[0] <= rom_address_a;
        dly_b[0] <= rom_address_b;
        for (int i = 1; i < LAT_B; i++) dly_b[i] <= dly_b[i-1];
    end
    assign rom_q_a = rom_fn(dly_a[LAT_A-1]);
    assign rom_q_b = rom_fn(dly_b[LAT_B-1]);

    // Reference model: search pointer, last address, queues of expected responses
    typedef struct {
        int          due;
        int          id;
        logic [12:0] addr;
    } exp_t;
    exp_t q_a[$];
    exp_t q_b[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          m_ptr  = 0;
    int          m_g    = -1;
    logic [12:0] m_addr = '0;
    bit          m_known = 1'b0;

    typedef struct {
        logic [3:0] req;
        int         exp_rr;
        int         exp_fp;
    } vec_t;
    vec_t tbl [21];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_grant();
        if (RST) return -1;
`ifdef CHAR_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (req[i]) return i;
`else
        for (int k = 0; k < N; k++) if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
`endif
        return -1;
    endfunction

    function automatic int onehot(input int g);
        return (g < 0) ? 0 : (1 << g);
    endfunction

    task automatic tick_check();
        exp_t e;
        bit   ev;
        @(negedge NCLK);
        m_g = model_grant();
        chk("gnt_a", int'(gnt_a), onehot(m_g));
        chk("gnt_b", int'(gnt_b), onehot(m_g));
        if (m_known) begin
            chk("rom_address_a", int'(rom_address_a), int'(m_addr));
            chk("rom_address_b", int'(rom_address_b), int'(m_addr));
            ev = (q_a.size() > 0) && (q_a[0].due == cyc);
            chk("rsp_valid_a", int'(rsp_valid_a), int'(ev));
            if (ev) begin
                e = q_a.pop_front();
                chk("rsp_id_a", int'(rsp_id_a), e.id);
                chk("rsp_data_a", int'(rsp_data_a), int'(rom_fn(e.addr)));
            end
            ev = (q_b.size() > 0) && (q_b[0].due == cyc);
            chk("rsp_valid_b", int'(rsp_valid_b), int'(ev));
            if (ev) begin
                e = q_b.pop_front();
                chk("rsp_id_b", int'(rsp_id_b), e.id);
                chk("rsp_data_b", int'(rsp_data_b), int'(rom_fn(e.addr)));
            end
        end
    endtask

    task automatic tick_adv();
        exp_t e;
        @(posedge NCLK);
        if (RST) begin
            m_ptr   = 0;
            m_addr  = '0;
            m_known = 1'b1;
            q_a.delete();
            q_b.delete();
        end else if (m_g >= 0) begin
            m_addr = {req_char[7*m_g +: 7], req_addr[6*m_g +: 6]};
            m_ptr  = (m_g + 1) % N;
            e.id   = m_g;
            e.addr = m_addr;
            e.due  = cyc + 2 + LAT_A;
            q_a.push_back(e);
            e.due  = cyc + 2 + LAT_B;
            q_b.push_back(e);
        end
        cyc++;
        #1;
    endtask

    task automatic cycle();
        tick_check();
        tick_adv();
    endtask

    task automatic do_reset(input int n);
        RST = 1'b1;
        req = '1;
        repeat (n) cycle();
        tick_check();
        chk("rst_gnt", int'(gnt_a | gnt_b), 0);
        chk("rst_rom_address", int'(rom_address_a | rom_address_b), 0);
        chk("rst_rsp_valid", int'(rsp_valid_a | rsp_valid_b), 0);
        chk("rst_rsp_id", int'(rsp_id_a | rsp_id_b), 0);
        chk("rst_rsp_data", int'(rsp_data_a | rsp_data_b), 0);
        tick_adv();
        RST = 1'b0;
        req = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int g;
        int exp;

        // Expected grants from reset; fixed-priority column for the macro build
        tbl[0]  = '{4'b1111, 0, 0};
        tbl[1]  = '{4'b1111, 1, 0};
        tbl[2]  = '{4'b1111, 2, 0};
        tbl[3]  = '{4'b1111, 3, 0};
        tbl[4]  = '{4'b1111, 0, 0};
        tbl[5]  = '{4'b1111, 1, 0};
        tbl[6]  = '{4'b1111, 2, 0};
        tbl[7]  = '{4'b1111, 3, 0};
        tbl[8]  = '{4'b0101, 0, 0};
        tbl[9]  = '{4'b0000, -1, -1};
        tbl[10] = '{4'b0101, 2, 0};
        tbl[11] = '{4'b0000, -1, -1};
        tbl[12] = '{4'b0101, 0, 0};
        tbl[13] = '{4'b1000, 3, 3};
        tbl[14] = '{4'b0010, 1, 1};
        tbl[15] = '{4'b0011, 0, 0};
        tbl[16] = '{4'b0011, 1, 0};
        tbl[17] = '{4'b0011, 0, 0};
        tbl[18] = '{4'b0011, 1, 0};
        tbl[19] = '{4'b0011, 0, 0};
        tbl[20] = '{4'b0010, 1, 1};

        do_reset(3);

        // Single request from requester 1, char 0x30 / addr 0x15
        req_char[13:7] = 7'h30;
        req_addr[11:6] = 6'h15;
        req = 4'b0010;
        tick_check();
        chk("t1_gnt", int'(gnt_a), 2);
        t0 = cyc;
        tick_adv();
        req = '0;
        tick_check();
        chk("t1_rom_address", int'(rom_address_a), 32'h0C15);
        tick_adv();
        while (cyc < t0 + 2 + LAT_A) cycle();
        tick_check();
        chk("t1_rsp_valid_a", int'(rsp_valid_a), 1);
        chk("t1_rsp_id_a", int'(rsp_id_a), 1);
        chk("t1_rsp_data_a", int'(rsp_data_a), int'(rom_fn(13'h0C15)));
        tick_adv();
        while (cyc < t0 + 2 + LAT_B) cycle();
        tick_check();
        chk("t1_rsp_valid_b", int'(rsp_valid_b), 1);
        chk("t1_rsp_id_b", int'(rsp_id_b), 1);
        chk("t1_rsp_data_b", int'(rsp_data_b), int'(rom_fn(13'h0C15)));
        tick_adv();

        // Grant-order table from a fresh reset
        do_reset(2);
        for (int i = 0; i < N; i++) begin
            req_char[7*i +: 7] = 7'(7'h41 + i);
            req_addr[6*i +: 6] = 6'(6'h09 * (i + 1));
        end
        for (int k = 0; k < 21; k++) begin
            req = tbl[k].req;
            tick_check();
`ifdef CHAR_ARB_FIXED_PRIO_EN
            exp = tbl[k].exp_fp;
`else
            exp = tbl[k].exp_rr;
`endif
            chk($sformatf("tbl_gnt[%0d]", k), int'(gnt_a), onehot(exp));
            tick_adv();
        end
        req = '0;
        repeat (6) cycle();

        // Reset one cycle after a grant: the read must never respond
        req = 4'b0100;
        tick_check();
        chk("t4_gnt", int'(gnt_a), 4);
        tick_adv();
        RST = 1'b1;
        req = '0;
        cycle();
        RST = 1'b0;
        tick_check();
        chk("t4_rom_address", int'(rom_address_a | rom_address_b), 0);
        chk("t4_rsp_valid", int'(rsp_valid_a | rsp_valid_b), 0);
        chk("t4_rsp_id", int'(rsp_id_a | rsp_id_b), 0);
        chk("t4_rsp_data", int'(rsp_data_a | rsp_data_b), 0);
        tick_adv();
        repeat (6) cycle();

        // Randomised traffic with occasional resets
        for (int c = 0; c < 400; c++) begin
            tick_check();
            g = m_g;
            tick_adv();
            RST = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < N; i++) begin
                if (req[i] && i == g) begin
                    req[i] = ($urandom_range(0, 3) == 0);
                    if (req[i]) begin
                        req_char[7*i +: 7] = 7'($urandom_range(0, 127));
                        req_addr[6*i +: 6] = 6'($urandom_range(0, 63));
                    end
                end else if (req[i]) begin
                    if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 1) == 1) begin
                    req[i] = 1'b1;
                    req_char[7*i +: 7] = 7'($urandom_range(0, 127));
                    req_addr[6*i +: 6] = 6'($urandom_range(0, 63));
                end
            end
        end

        // Drain and confirm every expected response arrived
        RST = 1'b0;
        req = '0;
        repeat (8) cycle();
        chk("drain_a", q_a.size(), 0);
        chk("drain_b", q_b.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
